irq_controller: RTL and testbench

// - Parametrised interrupt controller; replaces the fixed 4-bit interrupt input the core samples today.
// - Collects NUM_SRC external sources and synchronises them.
// - Latches each source per its mode: edge or level.
// - Arbitrates by programmable priority against a threshold.
// - Presents one registered request + ID to the CSR/trap logic, with a claim/complete handshake.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_gateway.sv | 64 ++++++
 rtl/irq_controller.sv | 130 +++++++++++++
 tb/tb_irq_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : irq_pkg                                                    |
// | Purpose : Shared config-word layout and types for irq_controller.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package irq_pkg;

    localparam int CFG_EN_BIT   = 0;
    localparam int CFG_EDGE_BIT = 1;
    localparam int CFG_PRIO_LSB = 2;

    // Upper bound on the controller's PRIO_W; stored priorities are zero-extended.
    localparam int PRIO_W_MAX   = 8;

    localparam int NO_IRQ_ID    = 0;

    typedef struct packed {
        logic [PRIO_W_MAX-1:0] prio;
        logic                  edge_mode;
        logic                  en;
    } src_cfg_t;

endpackage
`default_nettype wire

// File: rtl/irq_gateway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : irq_gateway                                                |
// | Purpose : Per-source synchroniser, edge detect, pending & in-service.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module irq_gateway
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    input  logic i_edge_mode,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending,
    output logic o_in_service
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_pending;
    logic                   r_in_service;
    logic                   w_s;
    logic                   w_rise;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= '0;
            r_s_d        <= 1'b0;
            r_pending    <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_sync[0] <= i_irq;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_s_d <= w_s;

            // A fresh edge coinciding with a claim must survive the claim.
            if (i_edge_mode) begin
                r_pending <= (r_pending & ~i_claim) | w_rise;
            end else begin
                r_pending <= w_s;
            end

            if (i_claim) begin
                r_in_service <= 1'b1;
            end else if (i_complete) begin
                r_in_service <= 1'b0;
            end
        end
    end

    assign o_pending    = r_pending;
    assign o_in_service = r_in_service;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : irq_controller                                             |
// | Purpose : Priority interrupt controller with claim/complete handshake|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_SRC + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic                cfg_we,
    input  logic [ID_W-1:0]     cfg_addr,
    input  logic [PRIO_W+1:0]   cfg_wdata,
    output logic [PRIO_W+1:0]   cfg_rdata,
    output logic                irq_req,
    output logic [ID_W-1:0]     irq_id,
    input  logic                claim,
    input  logic                complete,
    input  logic [ID_W-1:0]     complete_id
);

    src_cfg_t                r_cfg [NUM_SRC];
    logic [PRIO_W-1:0]       r_thr;
    logic                    r_irq_req;
    logic [ID_W-1:0]         r_irq_id;

    logic [NUM_SRC-1:0]      w_pending;
    logic [NUM_SRC-1:0]      w_in_service;
    logic [NUM_SRC-1:0]      w_claim_hit;
    logic [NUM_SRC-1:0]      w_complete_hit;
    logic [NUM_SRC-1:0]      w_eligible;
    logic                    w_claim_valid;
    logic                    w_win_valid;
    logic [ID_W-1:0]         w_win_id;
    logic [PRIO_W_MAX-1:0]   w_win_prio;

    assign w_claim_valid = claim & r_irq_req;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign w_claim_hit[i]    = w_claim_valid && (r_irq_id == ID_W'(i + 1));
            assign w_complete_hit[i] = complete && (complete_id == ID_W'(i + 1));

            irq_gateway #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_gateway (
                .clk          (clk),
                .rst          (rst),
                .i_irq        (irq_src[i]),
                .i_edge_mode  (r_cfg[i].edge_mode),
                .i_claim      (w_claim_hit[i]),
                .i_complete   (w_complete_hit[i]),
                .o_pending    (w_pending[i]),
                .o_in_service (w_in_service[i])
            );

            // The source being claimed this cycle is excluded so the request drops next cycle.
            assign w_eligible[i] = w_pending[i] & r_cfg[i].en & ~w_in_service[i] & ~w_claim_hit[i]
                                 & (r_cfg[i].prio > PRIO_W_MAX'(r_thr));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_cfg[i] <= '0;
            end
            r_thr <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_addr == ID_W'(i)) begin
                    r_cfg[i].en        <= cfg_wdata[CFG_EN_BIT];
                    r_cfg[i].edge_mode <= cfg_wdata[CFG_EDGE_BIT];
                    r_cfg[i].prio      <= PRIO_W_MAX'(cfg_wdata[CFG_PRIO_LSB +: PRIO_W]);
                end
            end
            if (cfg_addr == ID_W'(NUM_SRC)) begin
                r_thr <= cfg_wdata[PRIO_W-1:0];
            end
        end
    end

    // Strict '>' while scanning upward keeps ties on the lowest index.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = ID_W'(NO_IRQ_ID);
        w_win_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_eligible[i] && (!w_win_valid || (r_cfg[i].prio > w_win_prio))) begin
                w_win_valid = 1'b1;
                w_win_id    = ID_W'(i + 1);
                w_win_prio  = r_cfg[i].prio;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_req <= 1'b0;
            r_irq_id  <= ID_W'(NO_IRQ_ID);
        end else begin
            r_irq_req <= w_win_valid;
            r_irq_id  <= w_win_id;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_addr == ID_W'(i)) begin
                cfg_rdata = {r_cfg[i].prio[PRIO_W-1:0], r_cfg[i].edge_mode, r_cfg[i].en};
            end
        end
        if (cfg_addr == ID_W'(NUM_SRC)) begin
            cfg_rdata = (PRIO_W + 2)'(r_thr);
        end
    end

    assign irq_req = r_irq_req;
    assign irq_id  = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_irq_controller                                          |
// | Purpose : Directed + random bench against a cycle reference model.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_irq_controller;

    localparam int NUM = 4;
    localparam int PW  = 3;
    localparam int SS  = 2;
    localparam int IW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NUM-1:0] irq_src;
    logic           cfg_we;
    logic [IW-1:0]  cfg_addr;
    logic [PW+1:0]  cfg_wdata;
    logic [PW+1:0]  cfg_rdata;
    logic           irq_req;
    logic [IW-1:0]  irq_id;
    logic           claim;
    logic           complete;
    logic [IW-1:0]  complete_id;

    int n_total = 0;
    int n_bad   = 0;

    irq_controller #(
        .NUM_SRC     (NUM),
        .PRIO_W      (PW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .claim       (claim),
        .complete    (complete),
        .complete_id (complete_id)
    );

    always #5 clk = ~clk;

    // Reference model: raw sample history per edge, plus abstract per-source state.
    logic [NUM-1:0] samp_q[$];
    int  m_en[NUM], m_edm[NUM], m_prio[NUM], m_thr;
    bit  m_pend[NUM], m_isv[NUM];
    bit  m_req;
    int  m_id;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW+1:0] m_rdata(input int a);
        if (a < NUM) return {PW'(m_prio[a]), 1'(m_edm[a]), 1'(m_en[a])};
        if (a == NUM) return (PW + 2)'(m_thr);
        return '0;
    endfunction

    task automatic model_edge();
        int n, best, bp, cid, ci;
        bit cl, s, sd;
        logic [NUM-1:0] v;
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                m_en[i] = 0; m_edm[i] = 0; m_prio[i] = 0; m_pend[i] = 0; m_isv[i] = 0;
            end
            m_thr = 0; m_req = 0; m_id = 0;
            samp_q.delete();
            return;
        end
        n   = samp_q.size();
        cl  = claim && m_req;
        cid = m_id;
        best = -1; bp = -1;
        for (int i = 0; i < NUM; i++) begin
            if (m_pend[i] && m_en[i] != 0 && !m_isv[i] && !(cl && cid == i + 1)
                && m_prio[i] > m_thr && m_prio[i] > bp) begin
                best = i; bp = m_prio[i];
            end
        end
        for (int i = 0; i < NUM; i++) begin
            s = 0; sd = 0;
            if (n - SS >= 0)     begin v = samp_q[n - SS];     s  = v[i]; end
            if (n - SS - 1 >= 0) begin v = samp_q[n - SS - 1]; sd = v[i]; end
            if (m_edm[i] != 0) m_pend[i] = (m_pend[i] && !(cl && cid == i + 1)) || (s && !sd);
            else               m_pend[i] = s;
        end
        if (cl) m_isv[cid - 1] = 1;
        ci = int'(complete_id);
        if (complete && ci >= 1 && ci <= NUM && !(cl && ci == cid)) m_isv[ci - 1] = 0;
        if (cfg_we) begin
            if (cfg_addr < NUM) begin
                m_en[cfg_addr]   = int'(cfg_wdata[0]);
                m_edm[cfg_addr]  = int'(cfg_wdata[1]);
                m_prio[cfg_addr] = int'(cfg_wdata[PW+1:2]);
            end else if (cfg_addr == NUM) begin
                m_thr = int'(cfg_wdata[PW-1:0]);
            end
        end
        samp_q.push_back(irq_src);
        if (samp_q.size() > 8) void'(samp_q.pop_front());
        m_req = (best >= 0);
        m_id  = best + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_val("irq_req", irq_req, m_req);
        check_val("irq_id", irq_id, m_id);
        check_val("cfg_rdata", cfg_rdata, m_rdata(int'(cfg_addr)));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic wcfg(input int a, input int d);
        cfg_we = 1; cfg_addr = IW'(a); cfg_wdata = (PW + 2)'(d); tick(); cfg_we = 0;
    endtask

    function automatic int cw(input int en, input int edg, input int prio);
        return (prio << 2) | (edg << 1) | en;
    endfunction

    task automatic do_claim();
        claim = 1; tick(); claim = 0;
    endtask

    task automatic do_complete(input int id);
        complete = 1; complete_id = IW'(id); tick(); complete = 0;
    endtask

    task automatic pulse(input logic [NUM-1:0] m);
        irq_src = m; tick(); irq_src = '0;
    endtask

    initial begin
        rst = 1; irq_src = '0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
        claim = 0; complete = 0; complete_id = '0;
        ticks(2);
        rst = 0;
        check_val("rst_req", irq_req, 0);
        check_val("rst_id", irq_id, 0);

        // Basic edge source: latency, claim, complete
        wcfg(0, cw(1, 1, 3));
        pulse(4'b0001); ticks(2);
        check_val("t1_early", irq_req, 0);
        tick();
        check_val("t1_req", irq_req, 1);
        check_val("t1_id", irq_id, 1);
        do_claim();
        check_val("t1_claim_drop", irq_req, 0);
        do_complete(1); ticks(2);
        check_val("t1_no_new", irq_req, 0);

        // Priority and tie-break
        wcfg(1, cw(1, 1, 2)); wcfg(3, cw(1, 1, 5));
        pulse(4'b1010); ticks(3);
        check_val("t2_hi", irq_id, 4);
        do_claim();
        check_val("t2_next", irq_id, 2);
        do_claim(); do_complete(4); do_complete(2);
        wcfg(1, cw(1, 1, 5)); wcfg(2, cw(1, 1, 5));
        pulse(4'b0110); ticks(3);
        check_val("t2_tie", irq_id, 2);
        do_claim(); do_claim(); do_complete(2); do_complete(3);

        // Threshold masking and unmasking
        do_reset();
        wcfg(0, cw(1, 1, 3)); wcfg(4, 3);
        pulse(4'b0001); ticks(5);
        check_val("t3_masked", irq_req, 0);
        wcfg(4, 2); ticks(2);
        check_val("t3_req", irq_req, 1);
        check_val("t3_id", irq_id, 1);

        // Level source
        do_reset();
        wcfg(2, cw(1, 0, 1));
        irq_src = 4'b0100; ticks(4);
        check_val("t4_req", irq_id, 3);
        do_claim();
        check_val("t4_claim_drop", irq_req, 0);
        do_complete(3); tick();
        check_val("t4_reassert", irq_id, 3);
        do_claim();
        irq_src = '0; ticks(4);
        do_complete(3); ticks(2);
        check_val("t4_no_reassert", irq_req, 0);

        // Edge arriving in the claim cycle; claim+complete same cycle
        do_reset();
        wcfg(0, cw(1, 1, 3));
        irq_src = 4'b0001; tick(); irq_src = '0; tick();
        irq_src = 4'b0001; tick(); irq_src = '0; tick();
        check_val("t5_req", irq_id, 1);
        do_claim(); tick();
        check_val("t5_isv", irq_req, 0);
        do_complete(1); tick();
        check_val("t5_again", irq_id, 1);
        claim = 1; complete = 1; complete_id = 1; tick();
        claim = 0; complete = 0;
        pulse(4'b0001); ticks(4);
        check_val("t5_still_isv", irq_req, 0);
        do_complete(1); tick();
        check_val("t5_after", irq_id, 1);

        // Robustness
        do_claim();
        pulse(4'b0001); ticks(4);
        do_complete(0); tick();
        check_val("t6_cid0", irq_req, 0);
        do_complete(7); tick();
        check_val("t6_cid7", irq_req, 0);
        do_complete(1); tick();
        check_val("t6_cid1", irq_id, 1);
        do_claim();
        do_claim(); tick();
        check_val("t6_idle_claim", irq_req, 0);
        pulse(4'b0001); ticks(4);
        do_reset();
        check_val("t6_rst_req", irq_req, 0);
        check_val("t6_rst_id", irq_id, 0);
        for (int a = 0; a < 8; a++) begin
            cfg_addr = IW'(a); #1;
            check_val("t6_rst_rdata", cfg_rdata, 0);
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NUM; i++)
                if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
            cfg_we      = ($urandom_range(0, 9) == 0);
            cfg_addr    = IW'($urandom_range(0, 7));
            cfg_wdata   = (PW + 2)'($urandom_range(0, 31));
            claim       = ($urandom_range(0, 3) == 0);
            complete    = ($urandom_range(0, 3) == 0);
            complete_id = IW'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
